// File: rtl/key_expander.sv
// AES-128 key schedule: expands one cipher key into round keys 0..10 and
// writes them to the round-key register file, one key per clock.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // FIPS-197 S-box; entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[11'd2047 - {in_byte, 3'b000} -: 8];
endmodule

module key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [3:0]   iter_in,
    output logic         key_reg_load,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);
    // Handshake: start is a request taken only in IDLE; key_reg_load is a
    // one-cycle write strobe with no back-pressure, key_out/iter_in are
    // valid only while it is high and hold their last value otherwise.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [127:0] work_key, work_next;
    logic [3:0]   cnt, cnt_next;
    logic [7:0]   rcon, rcon_next;
    logic [127:0] key_out_next;
    logic [3:0]   iter_next;
    logic         load_next, busy_next, done_next;

    logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_adv;

    assign {w0, w1, w2, w3} = work_key;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    assign t_word   = sub_w3 ^ {rcon, 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
    assign rcon_adv = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_next   = state;
        work_next    = work_key;
        cnt_next     = cnt;
        rcon_next    = rcon;
        key_out_next = key_out;
        iter_next    = iter_in;
        load_next    = 1'b0;
        busy_next    = busy;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WRITE;
                    work_next  = key_in;
                    cnt_next   = 4'd0;
                    rcon_next  = 8'h01;
                    busy_next  = 1'b1;
                end
            end
            WRITE: begin
                key_out_next = work_key;
                iter_next    = cnt;
                load_next    = 1'b1;
                // The last write leaves the working key alone: no round 11.
                if (cnt == 4'(NUM_ROUNDS)) begin
                    state_next = DONE;
                end else begin
                    work_next = next_key;
                    cnt_next  = cnt + 4'd1;
                    rcon_next = rcon_adv;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            work_key     <= '0;
            cnt          <= '0;
            rcon         <= 8'h01;
            key_out      <= '0;
            iter_in      <= '0;
            key_reg_load <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            work_key     <= work_next;
            cnt          <= cnt_next;
            rcon         <= rcon_next;
            key_out      <= key_out_next;
            iter_in      <= iter_next;
            key_reg_load <= load_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: driver pushes expected round-key writes
// stamped with their cycle, a negedge monitor pops and compares them.

module tb_key_expander;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] key_out;
    logic [3:0]   iter_in;
    logic         key_reg_load;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    key_expander #(.NUM_ROUNDS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .key_out      (key_out),
        .iter_in      (iter_in),
        .key_reg_load (key_reg_load),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_rk [11] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    // scoreboard: {cycle[15:0], iter[3:0], key[127:0]} per expected write
    logic [147:0] exp_q [$];
    logic [15:0]  done_q [$];
    int n_cmp   = 0;
    int n_fail  = 0;
    int n_loads = 0;

    task automatic check(input string name, input logic [147:0] got, input logic [147:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_run(input int acc, input bit use_zero);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({16'(acc + 1 + i), 4'(i), use_zero ? zero_rk[i] : fips_rk[i]});
        end
        done_q.push_back(16'(acc + 12));
    endtask

    // monitor
    always @(negedge clk) begin
        if (key_reg_load) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_load: iter %0d key %h at cycle %0d, none expected",
                         iter_in, key_out, cyc);
            end else begin
                check("load", {16'(cyc), iter_in, key_out}, exp_q.pop_front());
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
            end else begin
                check("done_cycle", 148'(cyc), 148'(done_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [127:0] key, input bit use_zero, output int acc);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        acc = cyc;
        push_run(acc, use_zero);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Waits through a run (negedges after edges acc..acc+12), checking busy
    // and optionally poking start while the expander is not idle.
    task automatic wait_run(input int n_loads_before, input bit poke);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            check("busy", 148'(busy), 148'(k <= 11));
            if (poke) start = (k == 3 || k == 11);
        end
        start = 1'b0;
        check("load_count", 148'(n_loads - n_loads_before), 148'(11));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {key_out, iter_in, key_reg_load, busy, done, state_dbg}, 148'(0));
    endtask

    int acc, acc1, nl;

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        key_in = FIPS_KEY;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset_state");
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // FIPS-197 A.1 key
        nl = n_loads;
        issue(FIPS_KEY, 1'b0, acc);
        wait_run(nl, 1'b0);

        // all-zero key
        nl = n_loads;
        issue(ZERO_KEY, 1'b1, acc);
        wait_run(nl, 1'b0);

        // start pulses mid-run are ignored
        nl = n_loads;
        issue(FIPS_KEY, 1'b0, acc);
        wait_run(nl, 1'b1);

        // reset while iter 5 is being presented
        issue(FIPS_KEY, 1'b0, acc);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_run_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_mid_reset");
        nl = n_loads;
        issue(FIPS_KEY, 1'b0, acc);
        wait_run(nl, 1'b0);

        // start held for 30 sampled edges: runs every 13 cycles
        @(negedge clk);
        start  = 1'b1;
        key_in = FIPS_KEY;
        @(posedge clk);
        #1;
        acc1 = cyc;
        push_run(acc1, 1'b0);
        push_run(acc1 + 13, 1'b0);
        push_run(acc1 + 26, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);

        check("exp_q_drained", 148'(exp_q.size()), 148'(0));
        check("done_q_drained", 148'(done_q.size()), 148'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
